io_bus_arbiter: RTL and testbench

- Shares the single IO register bus between two requesters: the CPU load/store unit (cpu_) and the UART debug monitor (mon_).
- Sequences each access onto the bus strobes (dma_io_we / dma_io_radr_en) that feed the IO device chain (LED, UART, timers).
- Returns read data from the end of the device rdata chain to the requester that issued the read.
- One transaction in flight at a time; round-robin arbitration between the two requesters.

---
 rtl/io_bus_arbiter_if.sv | 46 ++++
 rtl/io_bus_arbiter.sv | 91 +++++++++
 tb/tb_io_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_if.sv
// Request/response channels of the CPU and monitor requesters plus the IO device bus.
// slave = arbiter side, master = requesters and device chain side.
interface io_bus_arbiter_if #(
   parameter int ADR_W = 14
);
   logic             cpu_io_req;
   logic             cpu_io_we;
   logic [ADR_W-1:0] cpu_io_adr;
   logic [31:0]      cpu_io_wdata;
   logic             cpu_io_gnt;
   logic             cpu_io_rvalid;
   logic [31:0]      cpu_io_rdata;

   logic             mon_io_req;
   logic             mon_io_we;
   logic [ADR_W-1:0] mon_io_adr;
   logic [31:0]      mon_io_wdata;
   logic             mon_io_gnt;
   logic             mon_io_rvalid;
   logic [31:0]      mon_io_rdata;

   logic             dma_io_we;
   logic [ADR_W-1:0] dma_io_wadr;
   logic [31:0]      dma_io_wdata;
   logic [ADR_W-1:0] dma_io_radr;
   logic             dma_io_radr_en;
   logic [31:0]      dma_io_rdata_in;

   modport slave (
      input  cpu_io_req, cpu_io_we, cpu_io_adr, cpu_io_wdata,
      output cpu_io_gnt, cpu_io_rvalid, cpu_io_rdata,
      input  mon_io_req, mon_io_we, mon_io_adr, mon_io_wdata,
      output mon_io_gnt, mon_io_rvalid, mon_io_rdata,
      output dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en,
      input  dma_io_rdata_in
   );

   modport master (
      output cpu_io_req, cpu_io_we, cpu_io_adr, cpu_io_wdata,
      input  cpu_io_gnt, cpu_io_rvalid, cpu_io_rdata,
      output mon_io_req, mon_io_we, mon_io_adr, mon_io_wdata,
      input  mon_io_gnt, mon_io_rvalid, mon_io_rdata,
      input  dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en,
      output dma_io_rdata_in
   );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the IO register bus between the CPU and the UART monitor.
// One access in flight: IDLE -> ISSUE (-> RDWAIT for reads) -> IDLE.
module io_bus_arbiter #(
   parameter int ADR_W = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   io_bus_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             owner_q, owner_d;   // 1 = monitor; also serves as last_owner
   logic             we_q, we_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [31:0]      wdata_q, wdata_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b1;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      logic sel_mon;
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      adr_d    = adr_q;
      wdata_d  = wdata_q;
      sel_mon  = 1'b0;

      bus.dma_io_we      = 1'b0;
      bus.dma_io_radr_en = 1'b0;
      bus.dma_io_wadr    = '0;
      bus.dma_io_radr    = '0;
      bus.dma_io_wdata   = '0;
      bus.cpu_io_gnt     = 1'b0;
      bus.mon_io_gnt     = 1'b0;
      bus.cpu_io_rvalid  = 1'b0;
      bus.mon_io_rvalid  = 1'b0;
      bus.cpu_io_rdata   = '0;
      bus.mon_io_rdata   = '0;

      case (state_q)
         IDLE: begin
            if (bus.cpu_io_req || bus.mon_io_req) begin
               // Monitor wins if alone, or on contention when the CPU went last.
               sel_mon = bus.mon_io_req && (!bus.cpu_io_req || !owner_q);
               owner_d = sel_mon;
               we_d    = sel_mon ? bus.mon_io_we    : bus.cpu_io_we;
               adr_d   = sel_mon ? bus.mon_io_adr   : bus.cpu_io_adr;
               wdata_d = sel_mon ? bus.mon_io_wdata : bus.cpu_io_wdata;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            bus.dma_io_we      = we_q;
            bus.dma_io_radr_en = !we_q;
            bus.dma_io_wadr    = adr_q;
            bus.dma_io_radr    = adr_q;
            bus.dma_io_wdata   = we_q ? wdata_q : 32'd0;
            bus.cpu_io_gnt     = !owner_q;
            bus.mon_io_gnt     = owner_q;
            state_d            = we_q ? IDLE : RDWAIT;
         end
         RDWAIT: begin
            bus.cpu_io_rvalid = !owner_q;
            bus.mon_io_rvalid = owner_q;
            bus.cpu_io_rdata  = owner_q ? 32'd0 : bus.dma_io_rdata_in;
            bus.mon_io_rdata  = owner_q ? bus.dma_io_rdata_in : 32'd0;
            state_d           = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: per-cycle schedule model plus directed literal checks.
module tb_io_bus_arbiter;
   localparam int ADR_W = 14;
   localparam int MAXC  = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   io_bus_arbiter_if #(.ADR_W(ADR_W)) bus ();
   io_bus_arbiter #(.ADR_W(ADR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic gc, gm, rc, rm, we, ren;
      logic [13:0] wadr, radr;
      logic [31:0] wdata, rc_data, rm_data;
   } obs_t;

   typedef struct packed {
      logic        we;
      logic [13:0] adr;
      logic [31:0] wdata;
   } cmd_t;

   obs_t        exp_tab [MAXC];
   cmd_t        cpu_q[$];
   cmd_t        mon_q[$];
   logic [31:0] dev_mem [16];
   logic [31:0] shadow [16];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int free_at  = 0;
   bit last_mon = 1'b1;

   int          gnt_cyc[$];
   bit          gnt_who[$];
   int          ren_cyc[$];
   int          we_n = 0;
   int          cpu_rv_n = 0;
   logic [31:0] cpu_rd[$];
   logic [31:0] mon_rd[$];
   int          mon_rv_cyc[$];

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.gc = bus.cpu_io_gnt;       o.gm = bus.mon_io_gnt;
      o.rc = bus.cpu_io_rvalid;    o.rm = bus.mon_io_rvalid;
      o.we = bus.dma_io_we;        o.ren = bus.dma_io_radr_en;
      o.wadr = bus.dma_io_wadr;    o.radr = bus.dma_io_radr;
      o.wdata = bus.dma_io_wdata;
      o.rc_data = bus.cpu_io_rdata; o.rm_data = bus.mon_io_rdata;
      return o;
   endfunction

   // Device chain stand-in: 16 registers, read data appears the cycle after radr_en.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) dev_mem[i] <= 32'hA000_0000 | i;
         bus.dma_io_rdata_in <= 32'd0;
      end else begin
         if (bus.dma_io_we) dev_mem[bus.dma_io_wadr[3:0]] <= bus.dma_io_wdata;
         if (bus.dma_io_radr_en) bus.dma_io_rdata_in <= dev_mem[bus.dma_io_radr[3:0]];
      end
   end

   // Model: when idle, pick an owner and book the grant/strobe cycle and the read-return cycle.
   always @(posedge clk) begin
      int   k;
      bit   pick_mon;
      cmd_t c;
      obs_t e;
      k = cyc;
      if (k == 0) for (int i = 0; i < MAXC; i++) exp_tab[i] = '0;
      if (!rst_n) begin
         last_mon = 1'b1;
         free_at  = k + 1;
         for (int i = 0; i < 16; i++) shadow[i] = 32'hA000_0000 | i;
         for (int j = 1; j <= 3; j++) if (k + j < MAXC) exp_tab[k + j] = '0;
      end else if (k >= free_at && (bus.cpu_io_req || bus.mon_io_req)) begin
         pick_mon = (bus.cpu_io_req && bus.mon_io_req) ? !last_mon : bus.mon_io_req;
         last_mon = pick_mon;
         c = pick_mon ? '{bus.mon_io_we, bus.mon_io_adr, bus.mon_io_wdata}
                      : '{bus.cpu_io_we, bus.cpu_io_adr, bus.cpu_io_wdata};
         e = '0;
         e.gc = !pick_mon; e.gm = pick_mon;
         e.wadr = c.adr;   e.radr = c.adr;
         if (c.we) begin
            e.we = 1'b1; e.wdata = c.wdata;
            shadow[c.adr[3:0]] = c.wdata;
            free_at = k + 2;
         end else begin
            e.ren = 1'b1;
            if (k + 2 < MAXC) begin
               exp_tab[k + 2] = '0;
               exp_tab[k + 2].rc = !pick_mon;
               exp_tab[k + 2].rm = pick_mon;
               if (pick_mon) exp_tab[k + 2].rm_data = shadow[c.adr[3:0]];
               else          exp_tab[k + 2].rc_data = shadow[c.adr[3:0]];
            end
            free_at = k + 3;
         end
         if (k + 1 < MAXC) exp_tab[k + 1] = e;
      end
      cyc = cyc + 1;
   end

   // Compare every cycle on the falling edge; addresses/wdata only matter in strobe cycles.
   always @(negedge clk) begin
      obs_t o, e;
      o = sample();
      e = (rst_n && cyc < MAXC) ? exp_tab[cyc] : '0;
      if (rst_n && !(e.we || e.ren)) begin
         o.wadr = '0; o.radr = '0; o.wdata = '0;
      end
      chk($sformatf("cycle%0d", cyc), o, e);
      if (o.gc) begin gnt_cyc.push_back(cyc); gnt_who.push_back(1'b0); end
      if (o.gm) begin gnt_cyc.push_back(cyc); gnt_who.push_back(1'b1); end
      if (o.ren) ren_cyc.push_back(cyc);
      if (o.we) we_n++;
      if (o.rc) begin cpu_rv_n++; cpu_rd.push_back(o.rc_data); end
      if (o.rm) begin mon_rd.push_back(o.rm_data); mon_rv_cyc.push_back(cyc); end
   end

   task automatic drive();
      if (cpu_q.size() > 0) begin
         bus.cpu_io_req = 1'b1; bus.cpu_io_we = cpu_q[0].we;
         bus.cpu_io_adr = cpu_q[0].adr; bus.cpu_io_wdata = cpu_q[0].wdata;
      end else begin
         bus.cpu_io_req = 1'b0; bus.cpu_io_we = 1'b0; bus.cpu_io_adr = '0; bus.cpu_io_wdata = '0;
      end
      if (mon_q.size() > 0) begin
         bus.mon_io_req = 1'b1; bus.mon_io_we = mon_q[0].we;
         bus.mon_io_adr = mon_q[0].adr; bus.mon_io_wdata = mon_q[0].wdata;
      end else begin
         bus.mon_io_req = 1'b0; bus.mon_io_we = 1'b0; bus.mon_io_adr = '0; bus.mon_io_wdata = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.cpu_io_req && bus.cpu_io_gnt) void'(cpu_q.pop_front());
      if (bus.mon_io_req && bus.mon_io_gnt) void'(mon_q.pop_front());
      drive();
   endtask

   task automatic run_until_idle(input string name);
      int n;
      n = 0;
      while ((cpu_q.size() > 0 || mon_q.size() > 0 || cyc <= free_at) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk({name, "_timeout"}, 0, 1);
      repeat (2) tick();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      cpu_q.delete(); mon_q.delete();
      drive();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int r, base, n0, w0, rv0;
      logic [7:0] pat;
      bit seen;
      drive();
      @(negedge clk);
      chk("reset_outputs", sample(), '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // CPU write alone to the LED register
      cpu_q.push_back('{1'b1, 14'h3F80, 32'h5});
      drive(); r = cyc;
      run_until_idle("t1");
      chk("t1_gnt_latency", gnt_cyc[$] - r, 1);
      chk("t1_owner", gnt_who[$], 1'b0);
      chk("t1_led", dev_mem[0][3:0], 4'h5);

      // Monitor read-back
      mon_q.push_back('{1'b0, 14'h3F80, 32'h0});
      drive();
      run_until_idle("t2");
      chk("t2_mon_rdata", mon_rd[$], 32'h5);
      chk("t2_rvalid_latency", mon_rv_cyc[$] - gnt_cyc[$], 1);

      // Simultaneous writes after reset: CPU first
      do_reset();
      cpu_q.push_back('{1'b1, 14'h3F80, 32'h3});
      mon_q.push_back('{1'b1, 14'h3F80, 32'hC});
      drive();
      run_until_idle("t3");
      chk("t3_order", {gnt_who[gnt_who.size()-2], gnt_who[$]}, 2'b01);
      chk("t3_gnt_spacing", gnt_cyc[$] - gnt_cyc[gnt_cyc.size()-2], 2);
      chk("t3_led", dev_mem[0][3:0], 4'hC);

      // Sustained contention, mixed reads and writes
      base = gnt_who.size();
      cpu_q.push_back('{1'b1, 14'h3F81, 32'h11});
      cpu_q.push_back('{1'b0, 14'h3F81, 32'h0});
      cpu_q.push_back('{1'b1, 14'h3F82, 32'h22});
      cpu_q.push_back('{1'b0, 14'h3F82, 32'h0});
      mon_q.push_back('{1'b1, 14'h3F80, 32'h1C});
      mon_q.push_back('{1'b0, 14'h3F80, 32'h0});
      mon_q.push_back('{1'b0, 14'h3F81, 32'h0});
      mon_q.push_back('{1'b1, 14'h3F83, 32'h33});
      drive();
      run_until_idle("t4");
      for (int i = 0; i < 8; i++) pat[i] = gnt_who[base + i];
      chk("t4_alternation", pat, 8'b1010_1010);
      chk("t4_span", gnt_cyc[base + 7] - gnt_cyc[base], 18);
      chk("t4_cpu_read81", cpu_rd[cpu_rd.size()-2], 32'h11);
      chk("t4_mon_read81", mon_rd[$], 32'h11);

      // Back-to-back CPU reads with req held
      n0 = ren_cyc.size(); w0 = we_n;
      cpu_q.push_back('{1'b0, 14'h3F8D, 32'h0});
      cpu_q.push_back('{1'b0, 14'h3F8E, 32'h0});
      cpu_q.push_back('{1'b0, 14'h3F80, 32'h0});
      drive();
      run_until_idle("t5");
      chk("t5_ren_count", ren_cyc.size() - n0, 3);
      chk("t5_ren_spacing1", ren_cyc[n0 + 1] - ren_cyc[n0], 3);
      chk("t5_ren_spacing2", ren_cyc[n0 + 2] - ren_cyc[n0 + 1], 3);
      chk("t5_no_write", we_n - w0, 0);
      chk("t5_rdata", {cpu_rd[cpu_rd.size()-3], cpu_rd[cpu_rd.size()-2], cpu_rd[$]},
          {32'hA000_000D, 32'hA000_000E, 32'h0000_001C});

      // Reset during RDWAIT: no rvalid, outputs cleared, fresh grant after release
      cpu_q.push_back('{1'b0, 14'h3F80, 32'h0});
      drive();
      seen = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
         tick();
         seen = bus.cpu_io_gnt;
      end
      if (!seen) chk("t6_gnt_timeout", 0, 1);
      rv0 = cpu_rv_n;
      @(posedge clk);
      #2 rst_n = 1'b0;
      cpu_q.delete(); drive();
      #1 chk("t6_outputs_in_reset", sample(), '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cpu_q.push_back('{1'b1, 14'h3F80, 32'h7});
      drive(); r = cyc;
      run_until_idle("t6");
      chk("t6_no_rvalid", cpu_rv_n - rv0, 0);
      chk("t6_gnt_latency", gnt_cyc[$] - r, 1);
      chk("t6_led", dev_mem[0][3:0], 4'h7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
